move_key_ctrl: RTL

- Front end for the player craft's move interface.
- Converts four raw push-buttons into the craft's single-cycle move_en/direction request stream.
- Per-key work: synchronise, debounce, arbitrate among held keys, and pace requests at a fixed step rate.
- Monitors the craft's moving feedback and flags a blocked craft (craft sitting at a screen bound).

---
 rtl/move_key_ctrl_pkg.sv | 39 +++
 rtl/move_key_ctrl_debounce.sv | 48 ++++
 rtl/move_key_ctrl.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/move_key_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : move_key_ctrl_pkg
// Description : Shared definitions for the craft move-key front end:
//               direction codes, FSM state encoding, default debounce and
//               step cycle counts, and the fixed-priority key picker.
// Revision    : 1.0 - initial release
// ============================================================================
package move_key_ctrl_pkg;

  // Direction codes carried on direct_o.
  typedef enum logic [1:0] {
    UP    = 2'd0,
    DOWN  = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FIRST  = 2'd1,
    REPEAT = 2'd2
  } state_e;

  // 10 ms debounce and 5 ms step at 50 MHz.
  localparam int DEF_DEB_CYCLES  = 500000;
  localparam int DEF_STEP_CYCLES = 250000;
  localparam int DEF_CNT_W       = 20;

  // Key vector layout is {up, down, left, right}; UP has highest priority.
  function automatic dir_e prio_dir(input logic [3:0] k);
    if (k[3])      return UP;
    else if (k[2]) return DOWN;
    else if (k[1]) return LEFT;
    else           return RIGHT;
  endfunction

endpackage
`default_nettype wire

// File: rtl/move_key_ctrl_debounce.sv
`default_nettype none
// ============================================================================
// Module      : key_debounce
// Description : Two-flop synchroniser plus counter debounce for one raw
//               push-button. The debounced level toggles once the synced
//               input has disagreed with it for DEB_CYCLES consecutive cycles.
// Ports       : clk, rst (async, active-high)
//               key_raw   - raw button level, asynchronous to clk
//               key_level - debounced level
// Revision    : 1.0 - initial release
// ============================================================================
module key_debounce #(
  parameter int DEB_CYCLES = 500000,
  parameter int CNT_W      = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic key_level
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [1:0]       sync;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync      <= 2'b00;
      cnt       <= '0;
      key_level <= 1'b0;
    end else begin
      sync <= {sync[0], key_raw};
      // Any cycle of agreement restarts the qualification window, so
      // glitches shorter than DEB_CYCLES never reach key_level.
      if (sync[1] == key_level) begin
        cnt <= '0;
      end else if (cnt == DEB_LAST) begin
        key_level <= ~key_level;
        cnt       <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/move_key_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : move_key_ctrl
// Description : Converts four raw push-buttons into a paced single-cycle
//               move request stream for the player craft, and flags a craft
//               that fails to move (sitting at a screen bound).
// Ports       : clk, rst (async, active-high)
//               key_up_i/key_down_i/key_left_i/key_right_i - raw buttons
//               moving_i  - craft moved on the previous request
//               move_en_o - one-cycle move request
//               direct_o  - direction code, valid with move_en_o
//               blocked_o - craft did not move in the held direction
//               keys_o    - debounced keys {up, down, left, right}
// Options     : MOVE_ACCEL_EN - after 8 pulses in one direction the repeat
//               spacing halves until the direction changes or keys release.
// Revision    : 1.0 - initial release
// ============================================================================
module move_key_ctrl
  import move_key_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES  = DEF_DEB_CYCLES,
  parameter int STEP_CYCLES = DEF_STEP_CYCLES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_up_i,
  input  logic       key_down_i,
  input  logic       key_left_i,
  input  logic       key_right_i,
  input  logic       moving_i,
  output logic       move_en_o,
  output logic [1:0] direct_o,
  output logic       blocked_o,
  output logic [3:0] keys_o
);

  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);

  logic [3:0] raw_keys;
  assign raw_keys = {key_up_i, key_down_i, key_left_i, key_right_i};

  for (genvar i = 0; i < 4; i++) begin : g_key
    key_debounce #(
      .DEB_CYCLES (DEB_CYCLES),
      .CNT_W      (CNT_W)
    ) u_deb (
      .clk       (clk),
      .rst       (rst),
      .key_raw   (raw_keys[i]),
      .key_level (keys_o[i])
    );
  end

  state_e           state, state_next;
  dir_e             active, active_next;
  logic [3:0]       keys_prev;
  logic [3:0]       rise;
  logic [1:0]       act_bit;
  logic [CNT_W-1:0] step_cnt;
  logic             dir_change;
  logic             at_last;
  logic             pulse;
  logic             restart;

`ifdef MOVE_ACCEL_EN
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(STEP_CYCLES / 2 - 1);
  logic [3:0] pulse_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pulse_cnt <= 4'd0;
    end else if (state_next == IDLE) begin
      pulse_cnt <= 4'd0;
    end else if (pulse) begin
      // Saturates at 8: only "eight or more" matters.
      if (restart)                pulse_cnt <= 4'd1;
      else if (pulse_cnt != 4'd8) pulse_cnt <= pulse_cnt + 1'b1;
    end
  end

  assign at_last = (pulse_cnt == 4'd8) ? (step_cnt == HALF_LAST)
                                       : (step_cnt == STEP_LAST);
`else
  assign at_last = (step_cnt == STEP_LAST);
`endif

  // Arbitration, next state and pulse decision. move_en_o/direct_o are
  // registered from this, so a pulse decided here shows up next cycle.
  always_comb begin
    rise        = keys_o & ~keys_prev;
    act_bit     = 2'd3 - active;
    active_next = active;
    if (rise != 4'd0) begin
      // Last pressed wins; same-cycle presses resolve by priority.
      active_next = prio_dir(rise);
    end else if (keys_o != 4'd0 && !keys_o[act_bit]) begin
      // Active key released with others still held: fall back.
      active_next = prio_dir(keys_o);
    end
    dir_change = (active_next != active);

    state_next = state;
    pulse      = 1'b0;
    restart    = 1'b0;
    case (state)
      IDLE: begin
        if (keys_o != 4'd0) begin
          state_next = FIRST;
          pulse      = 1'b1;
          restart    = 1'b1;
        end
      end
      FIRST: begin
        if (keys_o == 4'd0) begin
          state_next = IDLE;
        end else if (dir_change) begin
          state_next = FIRST;
          pulse      = 1'b1;
          restart    = 1'b1;
        end else begin
          state_next = REPEAT;
        end
      end
      REPEAT: begin
        if (keys_o == 4'd0) begin
          state_next = IDLE;
        end else if (dir_change) begin
          state_next = FIRST;
          pulse      = 1'b1;
          restart    = 1'b1;
        end else if (at_last) begin
          pulse = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      active    <= UP;
      keys_prev <= 4'd0;
      step_cnt  <= '0;
      move_en_o <= 1'b0;
      direct_o  <= UP;
      blocked_o <= 1'b0;
    end else begin
      state     <= state_next;
      active    <= active_next;
      keys_prev <= keys_o;
      move_en_o <= pulse;
      if (pulse) direct_o <= active_next;
      // Counter reads 0 during every pulse cycle.
      if (state_next == IDLE || pulse) step_cnt <= '0;
      else                             step_cnt <= step_cnt + 1'b1;
      // moving_i is judged on the edge closing each pulse cycle.
      if (state_next == IDLE || restart) blocked_o <= 1'b0;
      else if (move_en_o)                blocked_o <= ~moving_i;
    end
  end

endmodule
`default_nettype wire
